// File: rtl/vscale_debug_ctrl_pkg.sv
// vscale_debug_ctrl_pkg: shared encodings for the debug command sequencer
package vscale_debug_ctrl_pkg;
  localparam int DBG_REGNO_WIDTH = 13;
  typedef enum logic [1:0] {OP_ACCESS, OP_HALT, OP_RESUME, OP_RSVD} dbg_op_e;
  typedef enum logic [1:0] {ERR_OK, ERR_NOT_HALTED, ERR_TIMEOUT, ERR_UNSUPPORTED} dbg_err_e;
  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_HALT_WAIT   = 3'd1;
  localparam logic [2:0] S_RESUME_WAIT = 3'd2;
  localparam logic [2:0] S_RD_WAIT     = 3'd3;
  localparam logic [2:0] S_WR_WAIT     = 3'd4;
  localparam logic [2:0] S_RESP        = 3'd5;
  function automatic logic is_wait(input logic [2:0] s);
    return s inside {S_HALT_WAIT, S_RESUME_WAIT, S_RD_WAIT, S_WR_WAIT};
  endfunction
endpackage

// File: rtl/vscale_debug_ctrl_if.sv
// vscale_debug_ctrl_if: command/response channel between debug transport and sequencer
interface vscale_debug_ctrl_if #(
  parameter int XPR_LEN = 32,
  parameter int REGNO_WIDTH = 13
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic                   cmd_write;
  logic [REGNO_WIDTH-1:0] cmd_regno;
  logic [XPR_LEN-1:0]     cmd_wdata;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [XPR_LEN-1:0]     resp_data;
  logic [1:0]             resp_err;
  modport master (
    output cmd_valid, cmd_op, cmd_write, cmd_regno, cmd_wdata, resp_ready,
    input  cmd_ready, resp_valid, resp_data, resp_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_write, cmd_regno, cmd_wdata, resp_ready,
    output cmd_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/vscale_debug_timeout.sv
// vscale_debug_timeout: saturating wait-cycle counter; expired marks the last allowed wait cycle
module vscale_debug_timeout #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] ONE  = W'(1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != MAX) cnt <= cnt + ONE;
  end
  // cnt holds the number of completed wait cycles, so cnt == LAST is the final one
  assign expired = cnt == LAST;
endmodule

// File: rtl/vscale_debug_ctrl.sv
// vscale_debug_ctrl: sequences HALT/RESUME/ACCESS commands onto the core debug port with timeouts
module vscale_debug_ctrl
  import vscale_debug_ctrl_pkg::*;
#(
  parameter int XPR_LEN = 32,
  parameter int REGNO_WIDTH = DBG_REGNO_WIDTH,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vscale_debug_ctrl_if.slave     bus,
  output logic                   halted,
  output logic                   haltreq,
  input  logic                   haltack,
  output logic                   resumereq,
  input  logic                   resumeack,
  output logic [REGNO_WIDTH-1:0] register_index,
  output logic                   debug_read,
  output logic                   debug_write,
  output logic [XPR_LEN-1:0]     debug_wdata,
  input  logic [XPR_LEN-1:0]     debug_rdata,
  input  logic                   reg_rack,
  input  logic                   reg_wack
);
  logic [2:0] state, state_n, accept_state;
  logic [1:0] err_n, accept_err;
  logic       accept, ack, rd_ack, expired, done;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign rd_ack = state == S_RD_WAIT && reg_rack;
  assign ack = (state == S_HALT_WAIT && haltack) || (state == S_RESUME_WAIT && resumeack) ||
               rd_ack || (state == S_WR_WAIT && reg_wack);
  // an ack in the expiry cycle still counts as success
  assign done = is_wait(state) && (ack || expired);
  vscale_debug_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .reset_n(reset_n), .clr(accept), .en(is_wait(state)), .expired(expired)
  );
  always_comb begin
    accept_state = bus.cmd_op == OP_HALT   ? (halted ? S_RESP : S_HALT_WAIT) :
                   bus.cmd_op == OP_RESUME ? (halted ? S_RESUME_WAIT : S_RESP) :
                   (bus.cmd_op == OP_ACCESS && halted) ? (bus.cmd_write ? S_WR_WAIT : S_RD_WAIT) :
                   S_RESP;
    accept_err = bus.cmd_op == OP_RSVD ? ERR_UNSUPPORTED :
                 (bus.cmd_op == OP_ACCESS && !halted) ? ERR_NOT_HALTED : ERR_OK;
    state_n = accept ? accept_state : done ? S_RESP :
              (state == S_RESP && bus.resp_ready) ? S_IDLE : state;
    err_n = accept ? accept_err : done ? (ack ? ERR_OK : ERR_TIMEOUT) : bus.resp_err;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      bus.cmd_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_err   <= '0;
      halted         <= 1'b0;
      haltreq        <= 1'b0;
      resumereq      <= 1'b0;
      debug_read     <= 1'b0;
      debug_write    <= 1'b0;
      register_index <= '0;
      debug_wdata    <= '0;
    end else begin
      state          <= state_n;
      bus.cmd_ready  <= state_n == S_IDLE;
      bus.resp_valid <= state_n == S_RESP;
      bus.resp_err   <= err_n;
      bus.resp_data  <= rd_ack ? debug_rdata : accept ? '0 : bus.resp_data;
      halted         <= (state == S_HALT_WAIT && haltack) ? 1'b1 :
                        (state == S_RESUME_WAIT && resumeack) ? 1'b0 : halted;
      haltreq        <= state_n == S_HALT_WAIT;
      resumereq      <= state_n == S_RESUME_WAIT;
      debug_read     <= state_n == S_RD_WAIT;
      debug_write    <= state_n == S_WR_WAIT;
      if (accept) begin
        register_index <= bus.cmd_regno;
        debug_wdata    <= bus.cmd_wdata;
      end
    end
  end
endmodule

// File: tb/tb_vscale_debug_ctrl.sv
// tb_vscale_debug_ctrl: table-driven command vectors plus backpressure and reset sequences
module tb_vscale_debug_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        halted, haltreq, resumereq, debug_read, debug_write;
  logic        haltack = 1'b0, resumeack = 1'b0, reg_rack = 1'b0, reg_wack = 1'b0;
  logic [12:0] register_index;
  logic [31:0] debug_wdata;
  logic [31:0] debug_rdata = '0;
  int          errors = 0;
  int          checks = 0;

  vscale_debug_ctrl_if #(.XPR_LEN(32), .REGNO_WIDTH(13)) bus ();

  vscale_debug_ctrl #(.XPR_LEN(32), .REGNO_WIDTH(13), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .halted(halted), .haltreq(haltreq), .haltack(haltack),
    .resumereq(resumereq), .resumeack(resumeack),
    .register_index(register_index), .debug_read(debug_read), .debug_write(debug_write),
    .debug_wdata(debug_wdata), .debug_rdata(debug_rdata),
    .reg_rack(reg_rack), .reg_wack(reg_wack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        wr;
    logic [12:0] regno;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    int          lat;
    int          reqc;
    logic [1:0]  err;
    logic [31:0] data;
    logic        hlt;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic wr, input logic [12:0] regno, input logic [31:0] wdata);
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_write = wr;
    bus.cmd_regno = regno;
    bus.cmd_wdata = wdata;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run(input int idx, input vec_t v);
    int n = 1;
    int reqc = 0;
    debug_rdata = v.rdata;
    issue(v.op, v.wr, v.regno, v.wdata);
    while (!bus.resp_valid && n <= 40) begin
      if (haltreq || resumereq || debug_read || debug_write) reqc++;
      if (debug_read || debug_write)
        check($sformatf("v%0d_regidx", idx), {19'd0, register_index}, {19'd0, v.regno});
      if (debug_write)
        check($sformatf("v%0d_wdata", idx), debug_wdata, v.wdata);
      haltack   = haltreq && reqc == v.ack_at;
      resumeack = resumereq && reqc == v.ack_at;
      reg_rack  = debug_read && reqc == v.ack_at;
      reg_wack  = debug_write && reqc == v.ack_at;
      @(negedge clk);
      n++;
    end
    {haltack, resumeack, reg_rack, reg_wack} = 4'b0;
    check($sformatf("v%0d_latency", idx), n, v.lat);
    check($sformatf("v%0d_req_cycles", idx), reqc, v.reqc);
    check($sformatf("v%0d_req_low", idx), {28'd0, haltreq, resumereq, debug_read, debug_write}, 32'd0);
    check($sformatf("v%0d_err", idx), {30'd0, bus.resp_err}, {30'd0, v.err});
    check($sformatf("v%0d_data", idx), bus.resp_data, v.data);
    check($sformatf("v%0d_halted", idx), {31'd0, halted}, {31'd0, v.hlt});
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check($sformatf("v%0d_ready_after", idx), {30'd0, bus.cmd_ready, bus.resp_valid}, 32'd2);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {23'd0, bus.cmd_ready, bus.resp_valid, bus.resp_err, halted,
                           haltreq, resumereq, debug_read, debug_write}, 32'd0);
    check({name, "_regidx"}, {19'd0, register_index}, 32'd0);
    check({name, "_wdata"}, debug_wdata, 32'd0);
    check({name, "_rdata"}, bus.resp_data, 32'd0);
  endtask

  initial begin
    //            op    wr    regno     wdata         rdata         ack lat req err    data          hlt
    tbl[0]  = '{2'd1, 1'b0, 13'h0,    32'h0,        32'h0,        3,  4,  3,  2'd0, 32'h0,        1'b1};
    tbl[1]  = '{2'd1, 1'b0, 13'h0,    32'h0,        32'h0,        1,  1,  0,  2'd0, 32'h0,        1'b1};
    tbl[2]  = '{2'd0, 1'b0, 13'h1001, 32'h0,        32'hDEADBEEF, 1,  2,  1,  2'd0, 32'hDEADBEEF, 1'b1};
    tbl[3]  = '{2'd0, 1'b1, 13'h1005, 32'h12345678, 32'h55555555, 2,  3,  2,  2'd0, 32'h0,        1'b1};
    tbl[4]  = '{2'd3, 1'b0, 13'h0,    32'h0,        32'h0,        1,  1,  0,  2'd3, 32'h0,        1'b1};
    tbl[5]  = '{2'd0, 1'b0, 13'h0007, 32'h0,        32'hA5A5A5A5, 0,  9,  8,  2'd2, 32'h0,        1'b1};
    tbl[6]  = '{2'd2, 1'b0, 13'h0,    32'h0,        32'h0,        1,  2,  1,  2'd0, 32'h0,        1'b0};
    tbl[7]  = '{2'd2, 1'b0, 13'h0,    32'h0,        32'h0,        1,  1,  0,  2'd0, 32'h0,        1'b0};
    tbl[8]  = '{2'd0, 1'b0, 13'h1001, 32'h0,        32'h77777777, 1,  1,  0,  2'd1, 32'h0,        1'b0};
    tbl[9]  = '{2'd0, 1'b1, 13'h1005, 32'hCAFE0001, 32'h0,        1,  1,  0,  2'd1, 32'h0,        1'b0};
    tbl[10] = '{2'd1, 1'b0, 13'h0,    32'h0,        32'h0,        0,  9,  8,  2'd2, 32'h0,        1'b0};
    tbl[11] = '{2'd1, 1'b0, 13'h0,    32'h0,        32'h0,        8,  9,  8,  2'd0, 32'h0,        1'b1};
    tbl[12] = '{2'd2, 1'b0, 13'h0,    32'h0,        32'h0,        0,  9,  8,  2'd2, 32'h0,        1'b1};
    tbl[13] = '{2'd3, 1'b1, 13'h1FFF, 32'hFFFFFFFF, 32'h0,        1,  1,  0,  2'd3, 32'h0,        1'b1};
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_write = 1'b0;
    bus.cmd_regno = '0;
    bus.cmd_wdata = '0;
    bus.resp_ready = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);
    for (int i = 0; i < 14; i++) run(i, tbl[i]);

    // backpressure: read response must hold while resp_ready stays low
    debug_rdata = 32'hCAFEF00D;
    issue(2'd0, 1'b0, 13'h0022, 32'h0);
    check("bp_read_req", {31'd0, debug_read}, 32'd1);
    reg_rack = 1'b1;
    @(negedge clk);
    reg_rack = 1'b0;
    debug_rdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_flags", i), {29'd0, bus.resp_valid, bus.cmd_ready, debug_read}, 32'd4);
      check($sformatf("bp%0d_data", i), bus.resp_data, 32'hCAFEF00D);
      check($sformatf("bp%0d_err", i), {30'd0, bus.resp_err}, 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("bp_release", {30'd0, bus.cmd_ready, bus.resp_valid}, 32'd2);

    // reset during RD_WAIT clears everything without waiting for a clock edge
    issue(2'd0, 1'b0, 13'h0033, 32'h0);
    @(negedge clk);
    check("rst_mid_read_req", {31'd0, debug_read}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    run(99, '{2'd2, 1'b0, 13'h0, 32'h0, 32'h0, 1, 1, 0, 2'd0, 32'h0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
